// File: rtl/student_ss_analog_pkg.sv
// Shared types and field/status offsets for the student analog sequencer.
//   op_e     : PMOD command opcodes
//   state_e  : sequencer FSM states
//   *_LSB    : command field offsets within the synchronised gpi word
//   ST_*_OFS : status bit positions, counted down from GPIO_W (gpo[GPIO_W-ofs])
package student_ss_analog_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'b00,
    OP_WRITE   = 2'b01,
    OP_ENABLE  = 2'b10,
    OP_DISABLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_e;

  localparam int STROBE_BIT = 0;
  localparam int OP_LSB     = 1;
  localparam int OP_W       = 2;
  localparam int CH_LSB     = 3;

  localparam int N_STATUS    = 4;
  localparam int ST_EN_OFS   = 1;
  localparam int ST_RDY_OFS  = 2;
  localparam int ST_ERR_OFS  = 3;
  localparam int ST_BUSY_OFS = 4;

  // trim field sits directly above the channel field
  function automatic int trim_lsb(input int ch_w);
    return CH_LSB + ch_w;
  endfunction

endpackage

// File: rtl/student_ss_analog_seq_sync.sv
// analog_sync: W-bit two-flop synchroniser for asynchronous inputs.
//   clk_in    : destination clock
//   reset_int : async active-low reset, clears both stages
//   d         : asynchronous input
//   q         : synchronised output, 2 clk latency
module analog_sync #(
  parameter int W = 1
) (
  input  logic         clk_in,
  input  logic         reset_int,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/student_ss_analog_seq.sv
// student_ss_analog_seq: PMOD command decoder and power-up sequencer for
// N_CH analog black-box channels.
//   clk_in       : system clock
//   reset_int    : async active-low reset (released synchronously inside)
//   pmod_gpi     : command pins {trim, ch, op, strobe}, asynchronous
//   pmod_gpo     : status on top 4 pins {en, ready, err, busy} of last channel
//   pmod_gpio_oe : constant output-enable, ones on the top 4 pins
//   ana_en_o     : per-channel enable
//   ana_trim_o   : per-channel trim, channel c at [c*CTRL_W +: CTRL_W]
//   ana_ready_i  : per-channel ready, asynchronous
// WRITE/ENABLE start a settle window of SETTLE_CYCLES clocks followed by a
// one-cycle CHECK; an ENABLE whose channel is not ready by then is backed out
// and flags err. Strobes arriving while busy are dropped and flag err.
module student_ss_analog_seq
  import student_ss_analog_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int CTRL_W        = 6,
  parameter int SETTLE_CYCLES = 64,
  parameter int GPIO_W        = 16
) (
  input  logic                   clk_in,
  input  logic                   reset_int,
  input  logic [GPIO_W-1:0]      pmod_gpi,
  output logic [GPIO_W-1:0]      pmod_gpo,
  output logic [GPIO_W-1:0]      pmod_gpio_oe,
  output logic [N_CH-1:0]        ana_en_o,
  output logic [N_CH*CTRL_W-1:0] ana_trim_o,
  input  logic [N_CH-1:0]        ana_ready_i
);

  localparam int CH_W     = $clog2(N_CH);
  localparam int TRIM_LSB = trim_lsb(CH_W);
  localparam int FLD_W    = TRIM_LSB + CTRL_W;
  localparam int CNT_W    = $clog2(SETTLE_CYCLES + 1);

  generate
    if (FLD_W > GPIO_W - N_STATUS) begin : g_bad_fields
      $error("command fields do not fit below the status pins");
    end
    if (N_CH < 2 || (1 << CH_W) != N_CH) begin : g_bad_nch
      $error("N_CH must be a power of two >= 2");
    end
    if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("SETTLE_CYCLES must be >= 1");
    end
  endgenerate

  // reset: assert immediately, release two clocks later on a clean edge
  logic [1:0] rst_ff;
  logic       rst_n;

  always_ff @(posedge clk_in or negedge reset_int) begin
    if (!reset_int) rst_ff <= '0;
    else            rst_ff <= {rst_ff[0], 1'b1};
  end
  assign rst_n = rst_ff[1];

  // input synchronisers
  logic [GPIO_W-1:0] gpi_s;
  logic [N_CH-1:0]   rdy_s;

  analog_sync #(.W(GPIO_W)) u_gpi_sync (
    .clk_in    (clk_in),
    .reset_int (rst_n),
    .d         (pmod_gpi),
    .q         (gpi_s)
  );

  analog_sync #(.W(N_CH)) u_rdy_sync (
    .clk_in    (clk_in),
    .reset_int (rst_n),
    .d         (ana_ready_i),
    .q         (rdy_s)
  );

  // command fields, sampled in the strobe-edge cycle
  op_e               f_op;
  logic [CH_W-1:0]   f_ch;
  logic [CTRL_W-1:0] f_trim;
  logic              stb_q, stb_rise;

  assign f_op     = op_e'(gpi_s[OP_LSB +: OP_W]);
  assign f_ch     = gpi_s[CH_LSB +: CH_W];
  assign f_trim   = gpi_s[TRIM_LSB +: CTRL_W];
  assign stb_rise = gpi_s[STROBE_BIT] & ~stb_q;

  // pins between the trim field and the status pins carry nothing
  logic unused_gpi_hi;
  assign unused_gpi_hi = ^gpi_s[GPIO_W-1:FLD_W];

  // sequencer state
  state_e                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  op_e                          op_q, op_d;
  logic [CH_W-1:0]              ch_q, ch_d;
  logic                         err_q, err_d, err_set, err_clr;
  logic [N_CH-1:0]              en_q, en_d;
  logic [N_CH-1:0][CTRL_W-1:0]  trim_q, trim_d;
  logic [N_STATUS-1:0]          status_q, status_d;
  logic                         busy;

  assign busy = (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    ch_d    = ch_q;
    en_d    = en_q;
    trim_d  = trim_q;
    err_set = 1'b0;
    err_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (stb_rise) begin
          op_d = f_op;
          ch_d = f_ch;
          case (f_op)
            OP_NOP:     err_clr = 1'b1;
            OP_WRITE: begin
              trim_d[f_ch] = f_trim;
              cnt_d        = CNT_W'(SETTLE_CYCLES - 1);
              state_d      = ST_SETTLE;
            end
            OP_ENABLE: begin
              en_d[f_ch] = 1'b1;
              cnt_d      = CNT_W'(SETTLE_CYCLES - 1);
              state_d    = ST_SETTLE;
            end
            OP_DISABLE: en_d[f_ch] = 1'b0;
            default: ;
          endcase
        end
      end
      ST_SETTLE: begin
        if (stb_rise) err_set = 1'b1;
        if (cnt_q == '0) state_d = ST_CHECK;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CHECK: begin
        if (stb_rise) err_set = 1'b1;
        if (op_q == OP_ENABLE && !rdy_s[ch_q]) begin
          err_set    = 1'b1;
          en_d[ch_q] = 1'b0;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // a set in the same cycle as a clear wins
    err_d = (err_q & ~err_clr) | err_set;
  end

  // status word, ordered from the top pin downwards
  assign status_d = {en_q[ch_q], rdy_s[ch_q], err_q, busy};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      op_q     <= OP_NOP;
      ch_q     <= '0;
      err_q    <= 1'b0;
      en_q     <= '0;
      trim_q   <= '0;
      status_q <= '0;
      stb_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      ch_q     <= ch_d;
      err_q    <= err_d;
      en_q     <= en_d;
      trim_q   <= trim_d;
      status_q <= status_d;
      stb_q    <= gpi_s[STROBE_BIT];
    end
  end

  always_comb begin
    pmod_gpo                       = '0;
    pmod_gpo[GPIO_W-ST_EN_OFS]     = status_q[3];
    pmod_gpo[GPIO_W-ST_RDY_OFS]    = status_q[2];
    pmod_gpo[GPIO_W-ST_ERR_OFS]    = status_q[1];
    pmod_gpo[GPIO_W-ST_BUSY_OFS]   = status_q[0];
  end

  assign pmod_gpio_oe = {{N_STATUS{1'b1}}, {(GPIO_W-N_STATUS){1'b0}}};
  assign ana_en_o     = en_q;
  assign ana_trim_o   = trim_q;

endmodule

// File: tb/tb_student_ss_analog_seq.sv
module tb_student_ss_analog_seq;

  logic        clk_in = 1'b0;
  logic        reset_int;
  logic [15:0] pmod_gpi;
  logic [15:0] pmod_gpo;
  logic [15:0] pmod_gpio_oe;
  logic [3:0]  ana_en_o;
  logic [23:0] ana_trim_o;
  logic [3:0]  ana_ready_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  student_ss_analog_seq #(
    .N_CH(4), .CTRL_W(6), .SETTLE_CYCLES(64), .GPIO_W(16)
  ) dut (
    .clk_in       (clk_in),
    .reset_int    (reset_int),
    .pmod_gpi     (pmod_gpi),
    .pmod_gpo     (pmod_gpo),
    .pmod_gpio_oe (pmod_gpio_oe),
    .ana_en_o     (ana_en_o),
    .ana_trim_o   (ana_trim_o),
    .ana_ready_i  (ana_ready_i)
  );

  localparam logic [1:0] NOP = 2'b00, WR = 2'b01, EN = 2'b10, DIS = 2'b11;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  // fields set 2 clk ahead, strobe raised; returns one clk before acceptance
  task automatic send_pre(input logic [1:0] op, input int ch, input logic [5:0] tr);
    logic [1:0] c2;
    c2 = ch[1:0];
    pmod_gpi = '0;
    pmod_gpi[2:1]  = op;
    pmod_gpi[4:3]  = c2;
    pmod_gpi[10:5] = tr;
    tick(2);
    pmod_gpi[0] = 1'b1;
    tick(2);
  endtask

  // returns #1 after the acceptance edge
  task automatic send(input logic [1:0] op, input int ch, input logic [5:0] tr);
    send_pre(op, ch, tr);
    tick(1);
    pmod_gpi[0] = 1'b0;
  endtask

  task automatic test_reset;
    reset_int   = 1'b0;
    pmod_gpi    = '0;
    ana_ready_i = '0;
    tick(3);
    checks++; if (ana_en_o !== 4'h0) begin errors++; $display("FAIL rst_en got %h exp 0", ana_en_o); end
    reset_int = 1'b1;
    tick(10);
    checks++; if (ana_en_o !== 4'h0) begin errors++; $display("FAIL idle_en got %h exp 0", ana_en_o); end
    checks++; if (ana_trim_o !== 24'h0) begin errors++; $display("FAIL idle_trim got %h exp 0", ana_trim_o); end
    checks++; if (pmod_gpo !== 16'h0) begin errors++; $display("FAIL idle_gpo got %h exp 0", pmod_gpo); end
    checks++; if (pmod_gpio_oe !== 16'hF000) begin errors++; $display("FAIL oe got %h exp f000", pmod_gpio_oe); end
  endtask

  task automatic test_write;
    int nb, ne;
    send_pre(WR, 2, 6'h2A);
    checks++; if (ana_trim_o[17:12] !== 6'h00) begin errors++; $display("FAIL wr_early got %h exp 00", ana_trim_o[17:12]); end
    tick(1);
    pmod_gpi[0] = 1'b0;
    checks++; if (ana_trim_o[17:12] !== 6'h2A) begin errors++; $display("FAIL wr_trim got %h exp 2a", ana_trim_o[17:12]); end
    nb = 0; ne = 0;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      if (pmod_gpo[12]) nb++;
      if (pmod_gpo[13]) ne++;
    end
    checks++; if (nb !== 65) begin errors++; $display("FAIL wr_busy_len got %0d exp 65", nb); end
    checks++; if (ne !== 0) begin errors++; $display("FAIL wr_err got %0d exp 0", ne); end
    checks++; if (pmod_gpo[15:12] !== 4'b0000) begin errors++; $display("FAIL wr_status got %b exp 0000", pmod_gpo[15:12]); end
  endtask

  task automatic test_enable_ok;
    send(EN, 1, 6'h0);
    checks++; if (ana_en_o !== 4'b0010) begin errors++; $display("FAIL en1_set got %b exp 0010", ana_en_o); end
    tick(10);
    ana_ready_i[1] = 1'b1;
    tick(60);
    checks++; if (ana_en_o !== 4'b0010) begin errors++; $display("FAIL en1_hold got %b exp 0010", ana_en_o); end
    checks++; if (pmod_gpo[15:12] !== 4'b1100) begin errors++; $display("FAIL en1_status got %b exp 1100", pmod_gpo[15:12]); end
  endtask

  task automatic test_enable_fail;
    send(EN, 3, 6'h0);
    checks++; if (ana_en_o !== 4'b1010) begin errors++; $display("FAIL en3_set got %b exp 1010", ana_en_o); end
    tick(64);
    checks++; if (ana_en_o !== 4'b1010) begin errors++; $display("FAIL en3_pre_check got %b exp 1010", ana_en_o); end
    tick(1);
    checks++; if (ana_en_o !== 4'b0010) begin errors++; $display("FAIL en3_backout got %b exp 0010", ana_en_o); end
    tick(1);
    checks++; if (pmod_gpo[15:12] !== 4'b0010) begin errors++; $display("FAIL en3_status got %b exp 0010", pmod_gpo[15:12]); end
    send(NOP, 3, 6'h0);
    tick(1);
    checks++; if (pmod_gpo[15:12] !== 4'b0000) begin errors++; $display("FAIL nop_clear got %b exp 0000", pmod_gpo[15:12]); end
  endtask

  task automatic test_back_to_back;
    send(WR, 0, 6'h15);
    tick(5);
    send(EN, 3, 6'h0);
    checks++; if (ana_en_o !== 4'b0010) begin errors++; $display("FAIL drop_en got %b exp 0010", ana_en_o); end
    tick(1);
    checks++; if (pmod_gpo[13:12] !== 2'b11) begin errors++; $display("FAIL drop_err_busy got %b exp 11", pmod_gpo[13:12]); end
    tick(60);
    checks++; if (pmod_gpo[15:12] !== 4'b0010) begin errors++; $display("FAIL drop_status got %b exp 0010", pmod_gpo[15:12]); end
    checks++; if (ana_trim_o !== 24'h02A015) begin errors++; $display("FAIL drop_trim got %h exp 02a015", ana_trim_o); end
    send(NOP, 1, 6'h0);
    tick(1);
    checks++; if (pmod_gpo[15:12] !== 4'b1100) begin errors++; $display("FAIL drop_nop got %b exp 1100", pmod_gpo[15:12]); end
  endtask

  task automatic test_reset_mid_settle;
    int nb;
    send(EN, 0, 6'h0);
    checks++; if (ana_en_o !== 4'b0011) begin errors++; $display("FAIL en0_set got %b exp 0011", ana_en_o); end
    tick(43);
    reset_int = 1'b0;
    #1;
    checks++; if (ana_en_o !== 4'b0000) begin errors++; $display("FAIL mid_rst_en got %b exp 0000", ana_en_o); end
    checks++; if (ana_trim_o !== 24'h0) begin errors++; $display("FAIL mid_rst_trim got %h exp 0", ana_trim_o); end
    checks++; if (pmod_gpo !== 16'h0) begin errors++; $display("FAIL mid_rst_gpo got %h exp 0", pmod_gpo); end
    tick(3);
    reset_int = 1'b1;
    tick(80);
    checks++; if (ana_en_o !== 4'b0000) begin errors++; $display("FAIL post_rst_en got %b exp 0000", ana_en_o); end
    send(DIS, 0, 6'h0);
    nb = 0;
    for (int i = 0; i < 80; i++) begin
      tick(1);
      if (pmod_gpo[12]) nb++;
    end
    checks++; if (nb !== 0) begin errors++; $display("FAIL dis_busy got %0d exp 0", nb); end
    checks++; if (pmod_gpo[15:12] !== 4'b0000) begin errors++; $display("FAIL dis_status got %b exp 0000", pmod_gpo[15:12]); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_enable_ok();
    test_enable_fail();
    test_back_to_back();
    test_reset_mid_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
